serial_subtractor_16bit: RTL and testbench
==========================================

Name: serial_subtractor_16bit

Overview:
- Sequential two's-complement subtractor that consumes the 16-bit bitwise-inverted operand produced by the 16-bit negator stage directly upstream.
- Computes diff = A + notB + 1, which equals A - B, processing DIGIT_W bits per clock with a registered ripple carry.
- Produces the difference plus carry, signed-overflow and zero flags, using a start/busy/done handshake.
- Sits between the negator and the ALU result mux.

Parameters:
DIGIT_W, 4, bits added per clock; legal values 1, 2, 4, 8, 16. Derived N = 16/DIGIT_W is the number of digit cycles.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
A  input  16  minuend; sampled only on the edge that accepts start
notB  input  16  bitwise-inverted subtrahend from the negator stage; sampled with A
start  input  1  request pulse; honoured only in IDLE
busy  output  1  high while an operation is in progress (RUN)
done  output  1  single-cycle pulse when the result is updated
diff  output  16  A - B result, held between operations
carry_out  output  1  final carry; 1 = no unsigned borrow (A >= B unsigned)
overflow  output  1  signed overflow of A - B
zero  output  1  diff == 0

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE, busy=0, done=0, diff=0, carry_out=0, overflow=0, zero=0. Working registers and digit counter are cleared.
- Reset mid-operation: the operation is abandoned and no done pulse is issued. The previous result is lost because the outputs are cleared.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - On a start=1 edge, capture A and notB into working shift registers.
  - Set the carry register to 1; this supplies the +1 of two's complement.
  - Set count=0 and go to RUN. busy=1 from this edge.
- RUN: each edge does the following.
  - Add the low DIGIT_W bits of both working registers plus the carry register.
  - Shift the sum digit into the MSB end of the result shift register; shift both operand registers right by DIGIT_W.
  - Store the digit carry-out and increment count.
  - On the edge where count reaches N-1 (the Nth digit), go to DONE.
  - On that same edge, load diff from the completed result and load all flags. busy drops to 0.
- DONE: done=1 for exactly one cycle, then IDLE on the next edge.
- Latency: start accepted at edge 0; digits are processed at edges 1..N; done=1 and the new diff are visible in the cycle after edge N. Back-to-back throughput is one operation per N+2 cycles.
- start in RUN or DONE is ignored and not queued. Operands may change freely after the accepting edge.
- Output hold:
  - diff and the flags keep the previous result throughout RUN.
  - They change only on the completion edge or on reset.
- Flags, all computed from the final 16-bit sum:
  - carry_out = carry out of bit 15.
  - overflow = (A[15] == notB[15]) and (diff[15] != A[15]), using the captured operand values.
  - zero = (diff == 16'h0000).
- Width rule: the internal sum is DIGIT_W+1 bits per cycle; no other widening. The result is modulo 2^16.
- notB is used as-is; this block performs no inversion.

Test Plan:
1. DIGIT_W=4: A=16'h0005, notB=16'hFFFC, start pulse -> done 5 cycles after the start edge; diff=16'h0002, carry_out=1, overflow=0, zero=0; busy high for exactly 4 cycles.
2. A=16'h0003, notB=16'hFFFA -> diff=16'hFFFE, carry_out=0, overflow=0, zero=0.
3. A=16'h8000, notB=16'hFFFE (B=1) -> diff=16'h7FFF, carry_out=1, overflow=1.
4. A=16'h1234, notB=16'hEDCB -> diff=16'h0000, zero=1, carry_out=1, overflow=0. Repeat with DIGIT_W=1 and DIGIT_W=16 -> same result, done after 17 cycles and 2 cycles respectively.
5. Start op 1 (A=16'h0005, notB=16'hFFFC). Pulse start with A=16'h0100 in the cycle after the accept edge and again in the DONE cycle -> only one done pulse; diff=16'h0002; diff holds its old value during RUN.
6. Assert rst asynchronously (mid-cycle) during RUN of an op -> all outputs 0 immediately and no done pulse. After release, op A=16'h0010, notB=16'hFFF7 -> diff=16'h0008, carry_out=1.

Source files
------------

// File: rtl/serial_subtractor_16bit.sv
// Digit-serial two's-complement subtractor: diff = A + notB + 1, DIGIT_W bits per clock.
// The carry register is preloaded with 1 and supplies the +1; result and flags are held between operations.
module serial_subtractor_16bit #(
   parameter int DIGIT_W = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] A,
   input  logic [15:0] notB,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [15:0] diff,
   output logic        carry_out,
   output logic        overflow,
   output logic        zero
);
   localparam int N = 16 / DIGIT_W;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t       state_q, state_d;
   logic [15:0]  a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
   logic         c_q, c_d, a15_q, a15_d, b15_q, b15_d;
   logic         cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
   logic [4:0]   cnt_q, cnt_d;
   logic [DIGIT_W:0] dsum;
   logic [15:0]  res_nxt;

   assign dsum    = {1'b0, a_q[DIGIT_W-1:0]} + {1'b0, b_q[DIGIT_W-1:0]} + {{DIGIT_W{1'b0}}, c_q};
   // New digit enters at the MSB end so the full word is aligned after N digits.
   assign res_nxt = (res_q >> DIGIT_W) | (16'(dsum[DIGIT_W-1:0]) << (16 - DIGIT_W));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         diff_q  <= '0;
         c_q     <= 1'b0;
         a15_q   <= 1'b0;
         b15_q   <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         c_q     <= c_d;
         a15_q   <= a15_d;
         b15_q   <= b15_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      diff_d  = diff_q;
      c_d     = c_q;
      a15_d   = a15_q;
      b15_d   = b15_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = notB;
               a15_d   = A[15];
               b15_d   = notB[15];
               c_d     = 1'b1;
               res_d   = '0;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            a_d   = a_q >> DIGIT_W;
            b_d   = b_q >> DIGIT_W;
            res_d = res_nxt;
            c_d   = dsum[DIGIT_W];
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(N - 1)) begin
               state_d = S_DONE;
               diff_d  = res_nxt;
               cout_d  = dsum[DIGIT_W];
               ovf_d   = (a15_q == b15_q) && (res_nxt[15] != a15_q);
               zero_d  = (res_nxt == 16'h0000);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign busy      = (state_q == S_RUN);
   assign done      = (state_q == S_DONE);
   assign diff      = diff_q;
   assign carry_out = cout_q;
   assign overflow  = ovf_q;
   assign zero      = zero_q;
endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// Bench for serial_subtractor_16bit: three instances (DIGIT_W = 4, 1, 16) checked against a word-level arithmetic model.
module tb_serial_subtractor_16bit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] a_s = '0;
   logic [15:0] nb_s = '0;
   logic        start_w [3];
   logic        busy_w  [3];
   logic        done_w  [3];
   logic [15:0] diff_w  [3];
   logic        cout_w  [3];
   logic        ovf_w   [3];
   logic        zero_w  [3];
   logic [15:0] prev    [3];
   int          n_digits [3];
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   serial_subtractor_16bit #(.DIGIT_W(4)) u_dw4 (
      .clk(clk), .rst(rst), .A(a_s), .notB(nb_s), .start(start_w[0]),
      .busy(busy_w[0]), .done(done_w[0]), .diff(diff_w[0]),
      .carry_out(cout_w[0]), .overflow(ovf_w[0]), .zero(zero_w[0]));
   serial_subtractor_16bit #(.DIGIT_W(1)) u_dw1 (
      .clk(clk), .rst(rst), .A(a_s), .notB(nb_s), .start(start_w[1]),
      .busy(busy_w[1]), .done(done_w[1]), .diff(diff_w[1]),
      .carry_out(cout_w[1]), .overflow(ovf_w[1]), .zero(zero_w[1]));
   serial_subtractor_16bit #(.DIGIT_W(16)) u_dw16 (
      .clk(clk), .rst(rst), .A(a_s), .notB(nb_s), .start(start_w[2]),
      .busy(busy_w[2]), .done(done_w[2]), .diff(diff_w[2]),
      .carry_out(cout_w[2]), .overflow(ovf_w[2]), .zero(zero_w[2]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic chk_idle_zero(input int idx, input string tag);
      chk({tag, ".busy"}, 32'(busy_w[idx]), 0);
      chk({tag, ".done"}, 32'(done_w[idx]), 0);
      chk({tag, ".diff"}, 32'(diff_w[idx]), 0);
      chk({tag, ".flags"}, {29'd0, cout_w[idx], ovf_w[idx], zero_w[idx]}, 0);
   endtask

   // Word-level reference: A - B == A + notB + 1, modulo 2^16.
   task automatic model(input logic [15:0] a, input logic [15:0] nb,
                        output logic [15:0] d, output logic c, output logic v, output logic z);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, nb} + 17'd1;
      d = s[15:0];
      c = s[16];
      v = (a[15] == nb[15]) && (d[15] != a[15]);
      z = (d == 16'h0000);
   endtask

   task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] nb, input string tag);
      logic [15:0] ed;
      logic        ec, ev, ez, got, held;
      int          lat, bcnt;
      model(a, nb, ed, ec, ev, ez);
      a_s = a;
      nb_s = nb;
      start_w[idx] = 1'b1;
      @(posedge clk);
      #1;
      start_w[idx] = 1'b0;
      a_s = 16'($urandom);
      nb_s = 16'($urandom);
      bcnt = busy_w[idx] ? 1 : 0;
      held = (diff_w[idx] == prev[idx]);
      got = 1'b0;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (done_w[idx]) begin
            got = 1'b1;
            lat = k;
            break;
         end
         if (busy_w[idx]) bcnt++;
         if (diff_w[idx] != prev[idx]) held = 1'b0;
      end
      chk({tag, ".done_seen"}, 32'(got), 1);
      if (got) begin
         chk({tag, ".latency"}, lat, n_digits[idx]);
         chk({tag, ".busy_cycles"}, bcnt, n_digits[idx]);
         chk({tag, ".held_in_run"}, 32'(held), 1);
         chk({tag, ".diff"}, 32'(diff_w[idx]), 32'(ed));
         chk({tag, ".carry"}, 32'(cout_w[idx]), 32'(ec));
         chk({tag, ".ovf"}, 32'(ovf_w[idx]), 32'(ev));
         chk({tag, ".zero"}, 32'(zero_w[idx]), 32'(ez));
         chk({tag, ".busy_in_done"}, 32'(busy_w[idx]), 0);
         @(posedge clk);
         #1;
         chk({tag, ".done_pulse"}, 32'(done_w[idx]), 0);
         chk({tag, ".diff_after"}, 32'(diff_w[idx]), 32'(ed));
      end
      prev[idx] = ed;
   endtask

   initial begin
      int dcnt;
      logic [15:0] ra, rn;
      n_digits[0] = 4;
      n_digits[1] = 16;
      n_digits[2] = 1;
      for (int i = 0; i < 3; i++) begin
         start_w[i] = 1'b0;
         prev[i] = 16'h0000;
      end
      #12;
      for (int i = 0; i < 3; i++) chk_idle_zero(i, $sformatf("reset[%0d]", i));
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_op(0, 16'h0005, 16'hFFFC, "t1");
      run_op(0, 16'h0003, 16'hFFFA, "t2");
      run_op(0, 16'h8000, 16'hFFFE, "t3");
      run_op(0, 16'h1234, 16'hEDCB, "t4_dw4");
      run_op(1, 16'h1234, 16'hEDCB, "t4_dw1");
      run_op(2, 16'h1234, 16'hEDCB, "t4_dw16");

      // Starts during RUN and DONE must be ignored.
      a_s = 16'h0005;
      nb_s = 16'hFFFC;
      start_w[0] = 1'b1;
      @(posedge clk);
      #1;
      a_s = 16'h0100;
      dcnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (k == 1) start_w[0] = 1'b0;
         if (k > 0 && k < 4) chk("t5.held", 32'(diff_w[0]), 32'(prev[0]));
         @(posedge clk);
         #1;
         start_w[0] = 1'b0;
         if (done_w[0]) begin
            dcnt++;
            if (dcnt == 1) start_w[0] = 1'b1;
         end
      end
      chk("t5.done_count", dcnt, 1);
      chk("t5.diff", 32'(diff_w[0]), 32'h0002);
      chk("t5.busy_after", 32'(busy_w[0]), 0);
      prev[0] = 16'h0002;

      // Asynchronous reset in the middle of RUN.
      a_s = 16'h7777;
      nb_s = 16'h1111;
      start_w[0] = 1'b1;
      @(posedge clk);
      #1;
      start_w[0] = 1'b0;
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk_idle_zero(0, "t6.rst");
      chk("t6.dw1_diff", 32'(diff_w[1]), 0);
      @(posedge clk);
      #4;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) prev[i] = 16'h0000;
      dcnt = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         if (done_w[0]) dcnt++;
      end
      chk("t6.no_done", dcnt, 0);
      run_op(0, 16'h0010, 16'hFFF7, "t6_after");

      run_op(0, 16'hFFFF, 16'h0000, "edge_ffff");
      run_op(1, 16'h8000, 16'h8000, "edge_min");
      run_op(2, 16'h7FFF, 16'h7FFF, "edge_max");
      for (int r = 0; r < 36; r++) begin
         ra = 16'($urandom);
         rn = 16'($urandom);
         run_op(r % 3, ra, rn, $sformatf("rand%0d", r));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
